// File: rtl/fp_invsqrt_result_queue.sv
// fp_invsqrt_result_queue
// Valid/ready wrapper around the free-running, fixed-latency approx_fp_invsqrt
// pipe. A LAG-deep valid pipe marks which core cycles carry accepted words.
// Those results land in a DEPTH-entry output FIFO. A credit counter (words in
// flight plus words in the FIFO) throttles in_ready, so a result can never
// arrive at a full FIFO.
// Optional feature macro: INVSQRT_SPECIAL_EN. When it is defined, zero,
// denormal, negative, NaN and +inf inputs are classified at accept time, and
// a fixed IEEE result replaces the core output with out_exc set.
module fp_invsqrt_result_queue #(
  parameter int LAG   = 6,
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic [31:0] core_in,
  input  logic [31:0] core_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_exc
);

  localparam int PW = $clog2(DEPTH);
  localparam int OW = $clog2(DEPTH + 1);
  localparam logic [OW-1:0] DEPTH_C = OW'(DEPTH);
  localparam logic [OW-1:0] ONE_C   = OW'(1);

  logic           acc;
  logic           pop;
  logic           push;
  logic [LAG-1:0] vld;
  logic [OW-1:0]  occ;
  logic [OW-1:0]  count;
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [31:0]    mem_data [DEPTH];
  logic [31:0]    push_data;

  assign core_in   = in_data;
  // Credits come from registers only, so in_valid never feeds back into in_ready.
  assign in_ready  = (occ < DEPTH_C);
  assign out_valid = (count != '0);
  assign acc       = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign push      = vld[LAG-1];
  assign out_data  = mem_data[rd_ptr];

`ifdef INVSQRT_SPECIAL_EN
  typedef enum logic [1:0] {
    CLS_NORMAL = 2'd0,  // positive normal: take the core result
    CLS_ZERO   = 2'd1,  // zero or denormal: signed infinity
    CLS_NAN    = 2'd2,  // NaN or negative nonzero: quiet NaN
    CLS_PINF   = 2'd3   // +inf: +0
  } cls_e;

  cls_e           cls_in;
  cls_e           cls_pipe [LAG];
  logic [LAG-1:0] sgn_pipe;
  logic [DEPTH-1:0] mem_exc;
  logic           push_exc;

  // Classify the word at the input; the sign is carried separately for zeros.
  always_comb begin
    cls_in = CLS_NORMAL;
    if (in_data[30:23] == 8'h00)
      cls_in = CLS_ZERO;
    else if (in_data[30:23] == 8'hFF && in_data[22:0] != 23'h0)
      cls_in = CLS_NAN;
    else if (in_data == 32'h7F80_0000)
      cls_in = CLS_PINF;
    else if (in_data[31])
      cls_in = CLS_NAN;
  end

  // Class and sign travel alongside vld so they meet the matching core result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAG; i++) cls_pipe[i] <= CLS_NORMAL;
      sgn_pipe <= '0;
    end else begin
      cls_pipe[0] <= cls_in;
      sgn_pipe[0] <= in_data[31];
      for (int i = 1; i < LAG; i++) begin
        cls_pipe[i] <= cls_pipe[i-1];
        sgn_pipe[i] <= sgn_pipe[i-1];
      end
    end
  end

  // Pick either the core result or the fixed special-case constant.
  always_comb begin
    push_data = core_out;
    push_exc  = 1'b1;
    case (cls_pipe[LAG-1])
      CLS_ZERO: push_data = {sgn_pipe[LAG-1], 8'hFF, 23'h0};
      CLS_NAN:  push_data = 32'h7FC0_0000;
      CLS_PINF: push_data = 32'h0000_0000;
      default:  push_exc  = 1'b0;
    endcase
  end

  // Exception flags stored next to the data entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      mem_exc <= '0;
    else if (push)
      mem_exc[wr_ptr] <= push_exc;
  end

  assign out_exc = mem_exc[rd_ptr];
`else
  assign push_data = core_out;
  assign out_exc   = 1'b0;
`endif

  // Valid pipe mirrors the core latency; a reset drops everything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
    end else begin
      vld[0] <= acc;
      for (int i = 1; i < LAG; i++) vld[i] <= vld[i-1];
    end
  end

  // Credit counter: accepted words not yet popped downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      occ <= '0;
    else if (acc && !pop)
      occ <= occ + ONE_C;
    else if (pop && !acc)
      occ <= occ - ONE_C;
  end

  // FIFO storage; it is cleared on reset so out_data reads zero afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_data[i] <= '0;
    end else if (push) begin
      mem_data[wr_ptr] <= push_data;
    end
  end

  // FIFO pointers and count; push and pop together leave count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      assert (!(push && count == DEPTH_C));
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + ONE_C;
        2'b01:   count <= count - ONE_C;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_invsqrt_result_queue.sv
// Bench for fp_invsqrt_result_queue. It builds two instances: A (LAG=6,
// DEPTH=8) and B (LAG=1, DEPTH=2). Each instance is driven by a stand-in core
// with its own latency. A queue-based scoreboard holds every accepted word,
// its expected result and the cycle from which it may appear at the output.
module tb_fp_invsqrt_result_queue;

  localparam int LAG_A   = 6;
  localparam int DEPTH_A = 8;
  localparam int LAG_B   = 1;
  localparam int DEPTH_B = 2;

  logic clk = 1'b0;
  logic rst_n;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_exc;
  logic [31:0] a_in_data, a_core_in, a_core_out, a_out_data;
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_exc;
  logic [31:0] b_in_data, b_core_in, b_core_out, b_out_data;

  fp_invsqrt_result_queue #(.LAG(LAG_A), .DEPTH(DEPTH_A)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .core_in(a_core_in), .core_out(a_core_out),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_exc(a_out_exc)
  );

  fp_invsqrt_result_queue #(.LAG(LAG_B), .DEPTH(DEPTH_B)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .core_in(b_core_in), .core_out(b_core_out),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_exc(b_out_exc)
  );

  always #5 clk = ~clk;

  // Stand-in core. The magic constant is exact for even powers of two.
  function automatic logic [31:0] core_fn(input logic [31:0] x);
    return 32'h5F40_0000 - {1'b0, x[31:1]};
  endfunction

  logic [31:0] a_pipe [LAG_A];
  logic [31:0] b_pipe [LAG_B];

  always @(posedge clk) begin
    a_pipe[0] <= core_fn(a_core_in);
    for (int i = 1; i < LAG_A; i++) a_pipe[i] <= a_pipe[i-1];
    b_pipe[0] <= core_fn(b_core_in);
  end
  assign a_core_out = a_pipe[LAG_A-1];
  assign b_core_out = b_pipe[LAG_B-1];

  typedef struct packed { logic [31:0] d; logic e; } res_t;

  // Expected visible result for an accepted input word.
  function automatic res_t ref_result(input logic [31:0] x);
    res_t r;
    r.d = core_fn(x);
    r.e = 1'b0;
`ifdef INVSQRT_SPECIAL_EN
    if (x[30:23] == 8'h00) begin
      r.d = {x[31], 8'hFF, 23'h0}; r.e = 1'b1;
    end else if (x[30:23] == 8'hFF && x[22:0] != 23'h0) begin
      r.d = 32'h7FC0_0000; r.e = 1'b1;
    end else if (x == 32'h7F80_0000) begin
      r.d = 32'h0; r.e = 1'b1;
    end else if (x[31]) begin
      r.d = 32'h7FC0_0000; r.e = 1'b1;
    end
`endif
    return r;
  endfunction

  logic [31:0] specials [6] = '{32'h0000_0000, 32'h8000_0000, 32'hC080_0000,
                                32'h7F80_0000, 32'h7FC0_1234, 32'h0000_0001};

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    if ($urandom_range(0, 7) == 0) begin
      w = specials[$urandom_range(0, 5)];
    end else begin
      w = $urandom;
      w[31] = 1'b0;
      w[30:23] = 8'($urandom_range(1, 254));
    end
    return w;
  endfunction

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chkint(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct { logic [31:0] d; logic e; int rdy; } exp_t;
  exp_t qa[$];
  exp_t qb[$];
  int cyc = 0;

  // One clock cycle for both instances. Inputs are driven after the edge,
  // and outputs are checked at the falling edge against the scoreboards.
  task automatic cycle(input logic av, input logic [31:0] ax, input logic ar,
                       input logic bv, input logic [31:0] bx, input logic br,
                       output logic a_acc, output logic a_pop);
    res_t r;
    logic ev;
    @(posedge clk); #1;
    cyc++;
    a_in_valid = av; a_in_data = ax; a_out_ready = ar;
    b_in_valid = bv; b_in_data = bx; b_out_ready = br;
    @(negedge clk);
    chk1("a_in_ready", a_in_ready, qa.size() < DEPTH_A);
    ev = (qa.size() > 0) && (cyc >= qa[0].rdy);
    chk1("a_out_valid", a_out_valid, ev);
    if (ev && a_out_valid) begin
      chk32("a_out_data", a_out_data, qa[0].d);
      chk1("a_out_exc", a_out_exc, qa[0].e);
    end
    a_acc = av & a_in_ready;
    a_pop = a_out_valid & ar;
    if (a_pop && qa.size() > 0) void'(qa.pop_front());
    if (a_acc) begin
      r = ref_result(ax);
      qa.push_back('{d: r.d, e: r.e, rdy: cyc + 1 + LAG_A});
    end
    chk1("b_in_ready", b_in_ready, qb.size() < DEPTH_B);
    ev = (qb.size() > 0) && (cyc >= qb[0].rdy);
    chk1("b_out_valid", b_out_valid, ev);
    if (ev && b_out_valid) begin
      chk32("b_out_data", b_out_data, qb[0].d);
      chk1("b_out_exc", b_out_exc, qb[0].e);
    end
    if (b_out_valid && br && qb.size() > 0) void'(qb.pop_front());
    if (bv && b_in_ready) begin
      r = ref_result(bx);
      qb.push_back('{d: r.d, e: r.e, rdy: cyc + 1 + LAG_B});
    end
  endtask

  task automatic drain();
    logic ta, tp;
    for (int i = 0; i < 200 && (qa.size() > 0 || qb.size() > 0); i++)
      cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, ta, tp);
    chkint("drain_a_empty", qa.size(), 0);
    chkint("drain_b_empty", qb.size(), 0);
  endtask

  task automatic chk_reset_values(input string tag);
    chk1({tag, "_a_out_valid"}, a_out_valid, 1'b0);
    chk1({tag, "_a_in_ready"},  a_in_ready,  1'b1);
    chk32({tag, "_a_out_data"}, a_out_data,  32'h0);
    chk1({tag, "_a_out_exc"},   a_out_exc,   1'b0);
    chk1({tag, "_b_out_valid"}, b_out_valid, 1'b0);
    chk1({tag, "_b_in_ready"},  b_in_ready,  1'b1);
    chk32({tag, "_b_out_data"}, b_out_data,  32'h0);
    chk1({tag, "_b_out_exc"},   b_out_exc,   1'b0);
  endtask

  // mode: 0 = exc only, 1 = exact data, 2 = data within 2 %
  typedef struct { logic [31:0] x; logic [31:0] d; logic e; int mode; } vec_t;

  initial begin
    vec_t vt[$];
    logic ta, tp;
    int lat, n_acc, n_pop;
    logic [31:0] diff;

    vt.push_back('{x: 32'h3F80_0000, d: 32'h3F80_0000, e: 1'b0, mode: 2});
    vt.push_back('{x: 32'h4080_0000, d: 32'h3F00_0000, e: 1'b0, mode: 2});
    vt.push_back('{x: 32'h4180_0000, d: 32'h3E80_0000, e: 1'b0, mode: 2});
    vt.push_back('{x: 32'h3E80_0000, d: 32'h4000_0000, e: 1'b0, mode: 2});
`ifdef INVSQRT_SPECIAL_EN
    vt.push_back('{x: 32'h0000_0000, d: 32'h7F80_0000, e: 1'b1, mode: 1});
    vt.push_back('{x: 32'h8000_0000, d: 32'hFF80_0000, e: 1'b1, mode: 1});
    vt.push_back('{x: 32'hC080_0000, d: 32'h7FC0_0000, e: 1'b1, mode: 1});
    vt.push_back('{x: 32'h7F80_0000, d: 32'h0000_0000, e: 1'b1, mode: 1});
    vt.push_back('{x: 32'h7FC0_0001, d: 32'h7FC0_0000, e: 1'b1, mode: 1});
    vt.push_back('{x: 32'h4000_0000, d: 32'h0000_0000, e: 1'b0, mode: 0});
`endif

    rst_n = 1'b0;
    a_in_valid = 0; a_in_data = 0; a_out_ready = 0;
    b_in_valid = 0; b_in_data = 0; b_out_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_values("rst_low");
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk_reset_values("rst_rel");

    // Directed single words on A: exact latency and value.
    foreach (vt[i]) begin
      @(posedge clk); #1;
      a_in_valid = 1'b1; a_in_data = vt[i].x; a_out_ready = 1'b1;
      @(posedge clk); #1;
      a_in_valid = 1'b0;
      lat = 1;
      while (!a_out_valid && lat < LAG_A + 8) begin
        @(posedge clk); #1;
        lat++;
      end
      chkint($sformatf("vec%0d_latency", i), lat, LAG_A + 1);
      if (vt[i].mode == 1) chk32($sformatf("vec%0d_data", i), a_out_data, vt[i].d);
      if (vt[i].mode == 2) begin
        diff = (a_out_data > vt[i].d) ? a_out_data - vt[i].d : vt[i].d - a_out_data;
        chk1($sformatf("vec%0d_within_2pct", i), diff <= 32'h0002_8F5C, 1'b1);
      end
      chk1($sformatf("vec%0d_exc", i), a_out_exc, vt[i].e);
      @(posedge clk); #1;
    end
    a_out_ready = 1'b0;

    // Backpressure: only DEPTH words accepted, released in order afterwards.
    n_acc = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 32'h3F80_0000 + 32'(i << 16), 1'b0,
            1'($urandom_range(0, 1)), rand_word(), 1'($urandom_range(0, 1)), ta, tp);
      n_acc += int'(ta);
    end
    chkint("bp_accepts", n_acc, DEPTH_A);
    chk1("bp_in_ready_low", a_in_ready, 1'b0);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, ta, tp);
    chk1("bp_first_pop", tp, 1'b1);
    cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, ta, tp);
    chk1("bp_in_ready_back", a_in_ready, 1'b1);
    drain();

    // Steady state at full credit: one accept and one pop every cycle.
    for (int i = 0; i < 16; i++)
      cycle(1'b1, rand_word(), 1'b0, 1'b0, 32'h0, 1'b1, ta, tp);
    n_acc = 0; n_pop = 0;
    for (int i = 0; i < 1000; i++) begin
      cycle(1'b1, rand_word(), 1'b1,
            1'(i % 2), rand_word(), 1'((i / 2) % 2), ta, tp);
      if (i >= 20) begin
        n_acc += int'(ta);
        n_pop += int'(tp);
      end
    end
    chkint("ss_accepts", n_acc, 980);
    chkint("ss_pops", n_pop, 980);
    drain();

    // Random traffic on both instances.
    for (int i = 0; i < 2000; i++)
      cycle(1'($urandom_range(0, 3) != 0), rand_word(), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 1)), rand_word(), 1'($urandom_range(0, 1)), ta, tp);
    drain();

    // Reset mid-operation: words both in flight and in the FIFO are discarded.
    for (int i = 0; i < 8; i++)
      cycle(1'b1, rand_word(), 1'b0, 1'b1, rand_word(), 1'b0, ta, tp);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, ta, tp);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, ta, tp);
    chk1("mid_a_has_output", a_out_valid, 1'b1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk_reset_values("mid_rst");
    qa.delete();
    qb.delete();
    @(posedge clk); #3;
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++)
      cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1, ta, tp);
    for (int i = 0; i < 300; i++)
      cycle(1'($urandom_range(0, 1)), rand_word(), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), rand_word(), 1'($urandom_range(0, 1)), ta, tp);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
